// File: rtl/ltc2324_conv_ctrl.sv
// ltc2324_conv_ctrl
// -----------------
// Frame sequencer for the LTC2324 capture path. Each frame pulses CNV,
// waits out the conversion, then reads every enabled channel in turn
// through the single-lane deserializer. It gates SCK, marks the start and
// end of each channel, and tags the data with the channel index.
//
// Ports
//   clk_sdr      in   1  system/sample clock, all logic on the rising edge
//   reset        in   1  synchronous, active-high reset
//   enable       in   1  continuous mode: frames run back-to-back while high
//   single_shot  in   1  one-cycle request for a single frame (ignored while busy)
//   ch_mask      in   4  channel enables, bit i = channel i (bits >= NUM_CH ignored)
//   cnv          out  1  ADC CNV pin
//   sck_en       out  1  SCK gate for the ADC and the deserializer
//   rx_start     out  1  pulse on the first readout cycle of each channel
//   data_latch   out  1  pulse on the cycle after the last bit of each channel
//   channel      out  4  index of the channel being read
//   frame_cnt    out  8  frames started, mod 256
//   busy         out  1  high from the first CNV cycle through the end of WAIT
module ltc2324_conv_ctrl #(
    parameter int CNV_HIGH_CYC = 4,
    parameter int CONV_CYC     = 50,
    parameter int NUM_BITS     = 16,
    parameter int NUM_CH       = 4,
    parameter int PERIOD_CYC   = 200
) (
    input  logic       clk_sdr,
    input  logic       reset,
    input  logic       enable,
    input  logic       single_shot,
    input  logic [3:0] ch_mask,
    output logic       cnv,
    output logic       sck_en,
    output logic       rx_start,
    output logic       data_latch,
    output logic [3:0] channel,
    output logic [7:0] frame_cnt,
    output logic       busy
);

    localparam int TW = $clog2(PERIOD_CYC + 1);
    localparam int BW = $clog2(NUM_BITS + 1);
    localparam logic [3:0] CH_VALID = 4'((1 << NUM_CH) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNV,
        S_CONV,
        S_READ,
        S_LATCH,
        S_WAIT
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   timer_q;
    logic [BW-1:0]   bit_q;
    logic [3:0]      shadow_q;
    logic            cnv_q;
    logic            sck_en_q;
    logic            rx_start_q;
    logic            data_latch_q;
    logic [3:0]      channel_q;
    logic [7:0]      frame_cnt_q;
    logic            busy_q;

    logic [3:0]      mask_live;
    logic            start_ok;
    logic [3:0]      first_ch;
    logic [3:0]      next_ch;
    logic            has_next;

    assign mask_live = ch_mask & CH_VALID;
    assign start_ok  = |mask_live;

    // Scanning from the top down leaves the lowest qualifying index in place.
    always_comb begin
        first_ch = 4'd0;
        next_ch  = 4'd0;
        has_next = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (shadow_q[i]) begin
                first_ch = 4'(i);
                if (4'(i) > channel_q) begin
                    next_ch  = 4'(i);
                    has_next = 1'b1;
                end
            end
        end
    end

    // Outputs are assigned together with the state they belong to, so the
    // registered outputs always describe the state held in state_q.
    always_ff @(posedge clk_sdr) begin
        if (reset) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            bit_q        <= '0;
            shadow_q     <= '0;
            cnv_q        <= 1'b0;
            sck_en_q     <= 1'b0;
            rx_start_q   <= 1'b0;
            data_latch_q <= 1'b0;
            channel_q    <= 4'd0;
            frame_cnt_q  <= 8'd0;
            busy_q       <= 1'b0;
        end else begin
            rx_start_q   <= 1'b0;
            data_latch_q <= 1'b0;
            timer_q      <= timer_q + TW'(1);
            case (state_q)
                S_IDLE: begin
                    timer_q <= '0;
                    if ((enable || single_shot) && start_ok) begin
                        state_q     <= S_CNV;
                        shadow_q    <= mask_live;
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                        cnv_q       <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                S_CNV: begin
                    if (timer_q == TW'(CNV_HIGH_CYC - 1)) begin
                        state_q   <= S_CONV;
                        cnv_q     <= 1'b0;
                        channel_q <= first_ch;
                    end
                end
                S_CONV: begin
                    if (timer_q == TW'(CONV_CYC - 1)) begin
                        state_q    <= S_READ;
                        bit_q      <= '0;
                        sck_en_q   <= 1'b1;
                        rx_start_q <= 1'b1;
                    end
                end
                S_READ: begin
                    bit_q <= bit_q + BW'(1);
                    if (bit_q == BW'(NUM_BITS - 1)) begin
                        state_q      <= S_LATCH;
                        sck_en_q     <= 1'b0;
                        data_latch_q <= 1'b1;
                    end
                end
                S_LATCH: begin
                    if (has_next) begin
                        state_q    <= S_READ;
                        bit_q      <= '0;
                        channel_q  <= next_ch;
                        sck_en_q   <= 1'b1;
                        rx_start_q <= 1'b1;
                    end else begin
                        state_q   <= S_WAIT;
                        channel_q <= 4'd0;
                    end
                end
                S_WAIT: begin
                    if (timer_q == TW'(PERIOD_CYC - 1)) begin
                        timer_q <= '0;
                        // A continuous frame needs a non-empty mask just like
                        // a fresh start from IDLE.
                        if (enable && start_ok) begin
                            state_q     <= S_CNV;
                            shadow_q    <= mask_live;
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                            cnv_q       <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    cnv_q    <= 1'b0;
                    sck_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign cnv        = cnv_q;
    assign sck_en     = sck_en_q;
    assign rx_start   = rx_start_q;
    assign data_latch = data_latch_q;
    assign channel    = channel_q;
    assign frame_cnt  = frame_cnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ltc2324_conv_ctrl.sv
module tb_ltc2324_conv_ctrl;

    logic       clk_sdr     = 1'b0;
    logic       reset       = 1'b1;
    logic       enable      = 1'b0;
    logic       single_shot = 1'b0;
    logic [3:0] ch_mask     = 4'd0;
    logic       cnv;
    logic       sck_en;
    logic       rx_start;
    logic       data_latch;
    logic [3:0] channel;
    logic [7:0] frame_cnt;
    logic       busy;

    int n_cmp      = 0;
    int n_fail     = 0;
    int exp_frames = 0;

    ltc2324_conv_ctrl dut (
        .clk_sdr     (clk_sdr),
        .reset       (reset),
        .enable      (enable),
        .single_shot (single_shot),
        .ch_mask     (ch_mask),
        .cnv         (cnv),
        .sck_en      (sck_en),
        .rx_start    (rx_start),
        .data_latch  (data_latch),
        .channel     (channel),
        .frame_cnt   (frame_cnt),
        .busy        (busy)
    );

    always #5 clk_sdr = ~clk_sdr;

    // {cnv, sck_en, rx_start, data_latch, busy, channel}
    function automatic logic [8:0] obs_vec();
        return {cnv, sck_en, rx_start, data_latch, busy, channel};
    endfunction

    // Expected pin vector for frame cycle cyc. st[k] is the hand-derived
    // rx_start cycle of the k-th channel read, ch[k] its index; each read is
    // 16 SCK cycles followed by one latch cycle. Cycles outside 0..199 are idle.
    function automatic logic [8:0] exp_vec(input int cyc, input int nslot,
                                           input int st[4], input int ch[4]);
        logic       c, s, r, d, b;
        logic [3:0] n;
        c = (cyc >= 0) && (cyc < 4);
        b = (cyc >= 0) && (cyc < 200);
        s = 1'b0;
        r = 1'b0;
        d = 1'b0;
        n = 4'd0;
        if (cyc >= 4 && cyc < 50) n = 4'(ch[0]);
        for (int k = 0; k < nslot; k++) begin
            if (cyc >= st[k] && cyc <= st[k] + 15) begin
                s = 1'b1;
                r = (cyc == st[k]);
                n = 4'(ch[k]);
            end
            if (cyc == st[k] + 16) begin
                d = 1'b1;
                n = 4'(ch[k]);
            end
        end
        return {c, s, r, d, b, n};
    endfunction

    task automatic test_reset();
        int st[4] = '{50, 67, 84, 101};
        int ch[4] = '{0, 1, 2, 3};
        repeat (3) @(negedge clk_sdr);
        n_cmp++;
        if (obs_vec() !== 9'd0 || frame_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state got=%b/%0d want=%b/0", obs_vec(), frame_cnt, 9'd0);
        end
        reset       = 1'b0;
        ch_mask     = 4'b1111;
        single_shot = 1'b1;
        @(negedge clk_sdr);
        single_shot = 1'b0;
        exp_frames  = 1;
        $display("reset test: frame started, aborting at cycle 55");
        for (int cyc = 0; cyc <= 55; cyc++) begin
            n_cmp++;
            if (obs_vec() !== exp_vec(cyc, 4, st, ch)) begin
                n_fail++;
                $display("FAIL reset_prefix cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec(cyc, 4, st, ch));
            end
            if (cyc < 55) @(negedge clk_sdr);
        end
        reset = 1'b1;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk_sdr);
            n_cmp++;
            if (obs_vec() !== 9'd0 || frame_cnt !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_mid_read r=%0d got=%b/%0d want=%b/0", r, obs_vec(), frame_cnt, 9'd0);
            end
        end
        reset      = 1'b0;
        exp_frames = 0;
        ch_mask    = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sdr);
            n_cmp++;
            if (obs_vec() !== 9'd0 || frame_cnt !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_idle i=%0d got=%b/%0d want=%b/0", i, obs_vec(), frame_cnt, 9'd0);
            end
        end
    endtask

    task automatic test_single_all();
        int st[4] = '{50, 67, 84, 101};
        int ch[4] = '{0, 1, 2, 3};
        ch_mask     = 4'b1111;
        single_shot = 1'b1;
        @(negedge clk_sdr);
        single_shot = 1'b0;
        exp_frames++;
        $display("single shot mask=1111 frame %0d", exp_frames);
        for (int cyc = 0; cyc < 210; cyc++) begin
            n_cmp++;
            if (obs_vec() !== exp_vec(cyc, 4, st, ch)) begin
                n_fail++;
                $display("FAIL single_all cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec(cyc, 4, st, ch));
            end
            if (cyc == 0) begin
                n_cmp++;
                if (frame_cnt !== 8'(exp_frames)) begin
                    n_fail++;
                    $display("FAIL single_all_frame_cnt got=%0d want=%0d", frame_cnt, 8'(exp_frames));
                end
            end
            @(negedge clk_sdr);
        end
    endtask

    task automatic test_single_sparse();
        int st[4] = '{50, 67, 0, 0};
        int ch[4] = '{0, 2, 0, 0};
        ch_mask     = 4'b0101;
        single_shot = 1'b1;
        @(negedge clk_sdr);
        single_shot = 1'b0;
        exp_frames++;
        $display("single shot mask=0101 frame %0d", exp_frames);
        for (int cyc = 0; cyc < 210; cyc++) begin
            n_cmp++;
            if (obs_vec() !== exp_vec(cyc, 2, st, ch)) begin
                n_fail++;
                $display("FAIL single_sparse cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec(cyc, 2, st, ch));
            end
            if (cyc == 0) begin
                n_cmp++;
                if (frame_cnt !== 8'(exp_frames)) begin
                    n_fail++;
                    $display("FAIL single_sparse_frame_cnt got=%0d want=%0d", frame_cnt, 8'(exp_frames));
                end
            end
            // Busy-time request and mask change must both be ignored.
            if (cyc == 30) begin
                single_shot = 1'b1;
                ch_mask     = 4'b1111;
            end
            if (cyc == 31) single_shot = 1'b0;
            @(negedge clk_sdr);
        end
    endtask

    task automatic test_mask_change();
        int st[4] = '{50, 67, 84, 101};
        int ch[4] = '{0, 1, 2, 3};
        ch_mask = 4'b1111;
        enable  = 1'b1;
        @(negedge clk_sdr);
        exp_frames++;
        $display("enable frame %0d with mask change at 20, enable drop at 30", exp_frames);
        for (int cyc = 0; cyc < 220; cyc++) begin
            n_cmp++;
            if (obs_vec() !== exp_vec(cyc, 4, st, ch)) begin
                n_fail++;
                $display("FAIL mask_change cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec(cyc, 4, st, ch));
            end
            if (cyc == 20)  ch_mask = 4'b0001;
            if (cyc == 30)  enable = 1'b0;
            if (cyc == 120) single_shot = 1'b1;
            if (cyc == 121) single_shot = 1'b0;
            @(negedge clk_sdr);
        end
        n_cmp++;
        if (frame_cnt !== 8'(exp_frames)) begin
            n_fail++;
            $display("FAIL mask_change_frame_cnt got=%0d want=%0d", frame_cnt, 8'(exp_frames));
        end
    endtask

    task automatic test_empty_mask();
        ch_mask = 4'b0000;
        enable  = 1'b1;
        $display("enable with empty mask for 300 cycles");
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_sdr);
            n_cmp++;
            if (obs_vec() !== 9'd0 || frame_cnt !== 8'(exp_frames)) begin
                n_fail++;
                $display("FAIL empty_mask i=%0d got=%b/%0d want=%b/%0d", i, obs_vec(), frame_cnt, 9'd0, 8'(exp_frames));
            end
            if (i == 50) single_shot = 1'b1;
            if (i == 51) single_shot = 1'b0;
        end
        enable = 1'b0;
        @(negedge clk_sdr);
    endtask

    task automatic test_back_to_back();
        int st[4] = '{50, 0, 0, 0};
        int ch[4] = '{0, 0, 0, 0};
        int nf    = 254;
        ch_mask = 4'b0001;
        enable  = 1'b1;
        @(negedge clk_sdr);
        for (int f = 0; f < nf; f++) begin
            exp_frames++;
            $display("continuous frame %0d expect frame_cnt=%0d", f, exp_frames % 256);
            for (int cyc = 0; cyc < 200; cyc++) begin
                n_cmp++;
                if (obs_vec() !== exp_vec(cyc, 1, st, ch)) begin
                    n_fail++;
                    $display("FAIL back_to_back f=%0d cyc=%0d got=%b want=%b", f, cyc, obs_vec(), exp_vec(cyc, 1, st, ch));
                end
                if (cyc == 0) begin
                    n_cmp++;
                    if (frame_cnt !== 8'(exp_frames % 256)) begin
                        n_fail++;
                        $display("FAIL back_to_back_frame_cnt f=%0d got=%0d want=%0d", f, frame_cnt, exp_frames % 256);
                    end
                end
                if (f == nf - 1 && cyc == 100) enable = 1'b0;
                @(negedge clk_sdr);
            end
        end
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (obs_vec() !== 9'd0) begin
                n_fail++;
                $display("FAIL back_to_back_stop i=%0d got=%b want=%b", i, obs_vec(), 9'd0);
            end
            @(negedge clk_sdr);
        end
    endtask

    initial begin
        test_reset();
        test_single_all();
        test_single_sparse();
        test_mask_change();
        test_empty_mask();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
